ysyx_22040895_wbu: RTL and testbench
====================================

# ysyx_22040895_wbu

Write-back unit for the single-issue RV64 core. It is the register-file writer paired with the operand-read path. It accepts one retiring instruction per handshake and selects its result from the ALU, PC+4, immediate, or a load response. Load data is aligned and sign/zero-extended here. The unit drives one registered write-enable/address/data triple into the register file and a commit pulse.

## Interface
- `RegBus` width: 64 (shared define); `RegAddrBus` width: 5.
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid_wbu`  in  1  retiring instruction present
- `in_ready_wbu`  out  1  unit can accept this cycle
- `rd_addr_i_wbu`  in  5  destination register
- `rd_wen_i_wbu`  in  1  instruction writes rd
- `wb_sel_i_wbu`  in  2  source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
- `alu_res_i_wbu`  in  64  ALU result; for loads, the effective address (bits [2:0] = byte offset)
- `pc_i_wbu`  in  64  instruction PC
- `imm_i_wbu`  in  64  immediate (LUI)
- `ld_funct3_i_wbu`  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- `mem_rsp_valid_wbu`  in  1  load data valid
- `mem_rsp_data_wbu`  in  64  aligned doubleword containing the load
- `wen_o_wbu`  out  1  register-file write enable
- `waddr_o_wbu`  out  5  write address
- `wdata_o_wbu`  out  64  write data
- `commit_o_wbu`  out  1  one-cycle retire pulse
- `commit_pc_o_wbu`  out  64  PC of the retiring instruction
- Forwarding (macro only): `fwd_valid_o_wbu` 1, `fwd_addr_o_wbu` 5, `fwd_data_o_wbu` 64.

## Operation
- States: IDLE, WAIT_LOAD, COMMIT.
- `in_ready_wbu` = 1 in IDLE and COMMIT, 0 in WAIT_LOAD.
- Acceptance happens when `in_valid_wbu && in_ready_wbu`. All inputs are latched on acceptance.
  - Non-load: go to COMMIT.
  - `wb_sel`=01: go to WAIT_LOAD.
- WAIT_LOAD: stays until `mem_rsp_valid_wbu`, then goes to COMMIT with the extracted data latched. `mem_rsp_valid_wbu` is ignored in IDLE and COMMIT.
- COMMIT: outputs are valid for exactly this cycle.
  - With a new acceptance in the same cycle: next state is COMMIT or WAIT_LOAD per the new `wb_sel`.
  - Without a new acceptance: next state is IDLE.
- Load extraction: `sh = mem_rsp_data >> (8*offset)`, then take the low 8/16/32/64 bits per funct3, sign- or zero-extended to 64. Bytes past bit 63 read as zero; no misalignment trap.
- PC+4 wraps modulo 2^64.
- `wen_o_wbu` = COMMIT && latched `rd_wen` && (latched rd != 0). Writes to x0 are suppressed, but `commit_o_wbu` still pulses.
- `commit_o_wbu` = 1 in every COMMIT cycle.
- Outputs are registered. Outside COMMIT: `wen_o`/`commit_o` = 0; addr/data/pc hold their last values.

## Timing
- Reset: state IDLE; all outputs 0. Reset in any state aborts the in-flight instruction: no write, no commit.
- Non-load latency: accepted in cycle N, committed in N+1. Back-to-back non-loads sustain 1 per cycle.
- Load latency: accepted in N, response in cycle M ≥ N+1, committed in M+1.
- Response and new `in_valid` in the same WAIT_LOAD cycle: `in_ready`=0, so the new instruction is not accepted; it is accepted in the following COMMIT cycle.
- The upstream stage holds its inputs stable while `in_valid && !in_ready`.

## Configuration
- Macro: `YSYX_22040895_WBU_FWD_EN`.
- Defined: `fwd_valid_o_wbu` = `wen_o_wbu`, and `fwd_addr_o_wbu`/`fwd_data_o_wbu` = `waddr_o_wbu`/`wdata_o_wbu` in the same cycle. This is a combinational bypass copy of the commit write for the operand path.
- Undefined: the forwarding ports are driven constant 0; no other behaviour changes.

## Structure
- Shared define file: WB_SEL codes, load funct3 codes, state encodings, `RegBus`/`RegAddrBus`.
- One sub-module, `ysyx_22040895_ldext`: combinational offset shift plus width select and extend (inputs data, offset, funct3; output 64-bit result).
- FSM and output registers live in the top module.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0, `in_ready`=1.
- **ALU back-to-back:** accept rd=5 ALU=0x1234, next cycle rd=6 ALU=0x55 → `wen`=1 at N+1 with addr 5 / data 0x1234, then at N+2 with addr 6 / data 0x55, with `commit` high both cycles.
- **LB sign extend:** load LB, addr offset 3, rsp 2 cycles later with data 0x0000_0000_8000_0000 → commit 0xFFFF_FFFF_FFFF_FF80. LBU with the same stimulus → 0x80.
- **LW stall:** LW at offset 4 with rsp data 0x8765_4321_0000_0000, `in_valid` held high → `in_ready`=0 until the response; commit 0xFFFF_FFFF_8765_4321; the next instruction is accepted in the COMMIT cycle.
- **x0 / JAL:** JAL rd=0 pc=0x8000_0000 → `wen`=0, `commit`=1, `commit_pc`=0x8000_0000. With rd=1 → wdata 0x8000_0004.
- **Reset mid-load:** accept a load, assert `rst` in WAIT_LOAD with a response the same cycle → no `wen`/`commit`, state IDLE.

Source files
------------

// File: rtl/ysyx_22040895_wbu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040895_wbu_pkg
// Description : Shared definitions for the write-back unit. It holds the
//               register-bus widths, the write-back source select codes,
//               the load funct3 codes and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040895_wbu_pkg;

    // Register bus widths (RegBus / RegAddrBus)
    localparam int c_REG_BUS      = 64;
    localparam int c_REG_ADDR_BUS = 5;

    // Write-back source select
    localparam logic [1:0] c_WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] c_WB_SEL_IMM  = 2'b11;

    // Load funct3 codes
    localparam logic [2:0] c_LD_LB  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LW  = 3'b010;
    localparam logic [2:0] c_LD_LD  = 3'b011;
    localparam logic [2:0] c_LD_LBU = 3'b100;
    localparam logic [2:0] c_LD_LHU = 3'b101;
    localparam logic [2:0] c_LD_LWU = 3'b110;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_LOAD = 2'd1;
    localparam logic [1:0] c_ST_COMMIT    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_WAIT_LOAD = c_ST_WAIT_LOAD,
        ST_COMMIT    = c_ST_COMMIT
    } wbu_state_e;

endpackage : ysyx_22040895_wbu_pkg
`default_nettype wire

// File: rtl/ysyx_22040895_ldext.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040895_ldext
// Description : Load data extractor. It shifts the doubleword right by the
//               byte offset, then selects the low 8/16/32/64 bits and sign-
//               or zero-extends them to 64 bits according to funct3.
//               Bytes shifted in from above bit 63 read as zero.
// Ports       : i_data   [63:0] aligned doubleword from memory
//               i_offset [2:0]  byte offset of the access
//               i_funct3 [2:0]  load type
//               o_result [63:0] extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040895_ldext
    import ysyx_22040895_wbu_pkg::*;
(
    input  logic [c_REG_BUS-1:0] i_data,
    input  logic [2:0]           i_offset,
    input  logic [2:0]           i_funct3,
    output logic [c_REG_BUS-1:0] o_result
);

    logic [c_REG_BUS-1:0] w_sh;

    assign w_sh = i_data >> {i_offset, 3'b000};

    always_comb begin
        o_result = w_sh;
        case (i_funct3)
            c_LD_LB:  o_result = {{56{w_sh[7]}},  w_sh[7:0]};
            c_LD_LH:  o_result = {{48{w_sh[15]}}, w_sh[15:0]};
            c_LD_LW:  o_result = {{32{w_sh[31]}}, w_sh[31:0]};
            c_LD_LD:  o_result = w_sh;
            c_LD_LBU: o_result = {56'd0, w_sh[7:0]};
            c_LD_LHU: o_result = {48'd0, w_sh[15:0]};
            c_LD_LWU: o_result = {32'd0, w_sh[31:0]};
            // funct3 111 is not a legal load; pass the shifted word through
            default:  o_result = w_sh;
        endcase
    end

endmodule : ysyx_22040895_ldext
`default_nettype wire

// File: rtl/ysyx_22040895_wbu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040895_wbu
// Description : Write-back unit of the single-issue RV64 core. It accepts
//               one retiring instruction per valid/ready handshake, picks
//               its result (ALU, load, PC+4, immediate) and drives one
//               registered register-file write plus a commit pulse.
// Ports       : clk, rst                       clock, sync active-high reset
//               in_valid_wbu / in_ready_wbu    instruction handshake
//               rd_addr_i_wbu, rd_wen_i_wbu    destination register
//               wb_sel_i_wbu                   result source select
//               alu_res_i_wbu, pc_i_wbu,
//               imm_i_wbu, ld_funct3_i_wbu     instruction payload
//               mem_rsp_valid_wbu/_data_wbu    load response
//               wen_o/waddr_o/wdata_o_wbu      register-file write
//               commit_o/commit_pc_o_wbu       retire pulse and PC
//               fwd_valid/addr/data_o_wbu      operand-path bypass
// Config      : YSYX_22040895_WBU_FWD_EN - when defined, the forwarding
//               ports mirror the commit write; otherwise they are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040895_wbu
    import ysyx_22040895_wbu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_wbu,
    output logic                      in_ready_wbu,
    input  logic [c_REG_ADDR_BUS-1:0] rd_addr_i_wbu,
    input  logic                      rd_wen_i_wbu,
    input  logic [1:0]                wb_sel_i_wbu,
    input  logic [c_REG_BUS-1:0]      alu_res_i_wbu,
    input  logic [c_REG_BUS-1:0]      pc_i_wbu,
    input  logic [c_REG_BUS-1:0]      imm_i_wbu,
    input  logic [2:0]                ld_funct3_i_wbu,
    input  logic                      mem_rsp_valid_wbu,
    input  logic [c_REG_BUS-1:0]      mem_rsp_data_wbu,
    output logic                      wen_o_wbu,
    output logic [c_REG_ADDR_BUS-1:0] waddr_o_wbu,
    output logic [c_REG_BUS-1:0]      wdata_o_wbu,
    output logic                      commit_o_wbu,
    output logic [c_REG_BUS-1:0]      commit_pc_o_wbu,
    output logic                      fwd_valid_o_wbu,
    output logic [c_REG_ADDR_BUS-1:0] fwd_addr_o_wbu,
    output logic [c_REG_BUS-1:0]      fwd_data_o_wbu
);

    wbu_state_e                r_state;
    wbu_state_e                w_state_nxt;
    logic                      w_accept;
    logic [c_REG_BUS-1:0]      w_direct;
    logic [c_REG_BUS-1:0]      w_ld_data;

    // Fields of an in-flight load, held while waiting for the response
    logic [c_REG_ADDR_BUS-1:0] r_ld_rd;
    logic                      r_ld_rd_wen;
    logic [c_REG_BUS-1:0]      r_ld_pc;
    logic [2:0]                r_ld_offset;
    logic [2:0]                r_ld_funct3;

    // Output registers
    logic                      r_wen;
    logic [c_REG_ADDR_BUS-1:0] r_waddr;
    logic [c_REG_BUS-1:0]      r_wdata;
    logic                      r_commit;
    logic [c_REG_BUS-1:0]      r_commit_pc;

    assign in_ready_wbu = (r_state != ST_WAIT_LOAD);
    assign w_accept     = in_valid_wbu && in_ready_wbu;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_COMMIT: begin
                if (w_accept) begin
                    w_state_nxt = (wb_sel_i_wbu == c_WB_SEL_LOAD) ? ST_WAIT_LOAD : ST_COMMIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (mem_rsp_valid_wbu) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    always_comb begin
        w_direct = alu_res_i_wbu;
        case (wb_sel_i_wbu)
            c_WB_SEL_ALU: w_direct = alu_res_i_wbu;
            c_WB_SEL_PC4: w_direct = pc_i_wbu + 64'd4;
            c_WB_SEL_IMM: w_direct = imm_i_wbu;
            default:      w_direct = alu_res_i_wbu;
        endcase
    end

    ysyx_22040895_ldext u_ldext (
        .i_data   (mem_rsp_data_wbu),
        .i_offset (r_ld_offset),
        .i_funct3 (r_ld_funct3),
        .o_result (w_ld_data)
    );

    // ------------------------------------------------------------------
    // Load context and output registers. The output registers are loaded
    // on the edge that enters COMMIT, so they are valid during COMMIT.
    // Acceptance and a load response never coincide because in_ready is
    // low in WAIT_LOAD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_rd     <= '0;
            r_ld_rd_wen <= 1'b0;
            r_ld_pc     <= '0;
            r_ld_offset <= '0;
            r_ld_funct3 <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_commit    <= 1'b0;
            r_commit_pc <= '0;
        end else begin
            r_wen    <= 1'b0;
            r_commit <= 1'b0;
            if (w_accept) begin
                r_ld_rd     <= rd_addr_i_wbu;
                r_ld_rd_wen <= rd_wen_i_wbu;
                r_ld_pc     <= pc_i_wbu;
                r_ld_offset <= alu_res_i_wbu[2:0];
                r_ld_funct3 <= ld_funct3_i_wbu;
                if (wb_sel_i_wbu != c_WB_SEL_LOAD) begin
                    r_wen       <= rd_wen_i_wbu && (rd_addr_i_wbu != '0);
                    r_waddr     <= rd_addr_i_wbu;
                    r_wdata     <= w_direct;
                    r_commit    <= 1'b1;
                    r_commit_pc <= pc_i_wbu;
                end
            end else if ((r_state == ST_WAIT_LOAD) && mem_rsp_valid_wbu) begin
                r_wen       <= r_ld_rd_wen && (r_ld_rd != '0);
                r_waddr     <= r_ld_rd;
                r_wdata     <= w_ld_data;
                r_commit    <= 1'b1;
                r_commit_pc <= r_ld_pc;
            end
        end
    end

    assign wen_o_wbu       = r_wen;
    assign waddr_o_wbu     = r_waddr;
    assign wdata_o_wbu     = r_wdata;
    assign commit_o_wbu    = r_commit;
    assign commit_pc_o_wbu = r_commit_pc;

`ifdef YSYX_22040895_WBU_FWD_EN
    assign fwd_valid_o_wbu = r_wen;
    assign fwd_addr_o_wbu  = r_waddr;
    assign fwd_data_o_wbu  = r_wdata;
`else
    assign fwd_valid_o_wbu = 1'b0;
    assign fwd_addr_o_wbu  = '0;
    assign fwd_data_o_wbu  = '0;
`endif

endmodule : ysyx_22040895_wbu
`default_nettype wire

// File: tb/tb_ysyx_22040895_wbu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040895_wbu
// Description : Self-checking bench for the write-back unit. Directed
//               scenarios plus a randomized instruction stream checked
//               against a behavioural model of the write-back rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040895_wbu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic [1:0]  wb_sel;
    logic [63:0] alu_res;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  ld_funct3;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        wen_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        commit_o;
    logic [63:0] commit_pc_o;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [63:0] fwd_data;

    int n_pass  = 0;
    int n_total = 0;

    // Last committed addr/data/pc, used to check hold behaviour
    logic [4:0]  last_addr;
    logic [63:0] last_data;
    logic [63:0] last_pc;

    ysyx_22040895_wbu dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid_wbu      (in_valid),
        .in_ready_wbu      (in_ready),
        .rd_addr_i_wbu     (rd_addr),
        .rd_wen_i_wbu      (rd_wen),
        .wb_sel_i_wbu      (wb_sel),
        .alu_res_i_wbu     (alu_res),
        .pc_i_wbu          (pc),
        .imm_i_wbu         (imm),
        .ld_funct3_i_wbu   (ld_funct3),
        .mem_rsp_valid_wbu (rsp_valid),
        .mem_rsp_data_wbu  (rsp_data),
        .wen_o_wbu         (wen_o),
        .waddr_o_wbu       (waddr_o),
        .wdata_o_wbu       (wdata_o),
        .commit_o_wbu      (commit_o),
        .commit_pc_o_wbu   (commit_pc_o),
        .fwd_valid_o_wbu   (fwd_valid),
        .fwd_addr_o_wbu    (fwd_addr),
        .fwd_data_o_wbu    (fwd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load extraction, from arithmetic on the byte count
    function automatic logic [63:0] ref_load(input logic [63:0] d, input int off, input int f3);
        logic [63:0] sh;
        logic [63:0] val;
        int          nbytes;
        bit          sgn;
        sh = d >> (8 * off);
        case (f3)
            0:       begin nbytes = 1; sgn = 1'b1; end
            1:       begin nbytes = 2; sgn = 1'b1; end
            2:       begin nbytes = 4; sgn = 1'b1; end
            4:       begin nbytes = 1; sgn = 1'b0; end
            5:       begin nbytes = 2; sgn = 1'b0; end
            6:       begin nbytes = 4; sgn = 1'b0; end
            default: begin nbytes = 8; sgn = 1'b0; end
        endcase
        if (nbytes == 8) return sh;
        val = sh % (64'd1 << (8 * nbytes));
        if (sgn && (val >= (64'd1 << (8 * nbytes - 1))))
            val = val - (64'd1 << (8 * nbytes));
        return val;
    endfunction

    function automatic logic [134:0] observed();
        return {wen_o, waddr_o, wdata_o, commit_o, commit_pc_o};
    endfunction

    task automatic drive(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                         input logic [63:0] alu, input logic [63:0] p,
                         input logic [63:0] im, input logic [2:0] f3);
        in_valid  = 1'b1;
        rd_addr   = rd;
        rd_wen    = we;
        wb_sel    = sel;
        alu_res   = alu;
        pc        = p;
        imm       = im;
        ld_funct3 = f3;
    endtask

    task automatic test_reset();
        logic [134:0] exp;
        rst = 1'b1; in_valid = 1'b0; rsp_valid = 1'b0;
        tick(); tick();
        exp = '0;
        n_total++;
        if ({observed(), in_ready, fwd_valid, fwd_addr, fwd_data} !== {exp, 1'b1, 70'd0})
            $display("FAIL reset_outputs got %h ready=%b fwd=%b required %h ready=1 fwd=0",
                     observed(), in_ready, fwd_valid, exp);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_back_to_back();
        logic [134:0] exp;
        drive(5'd5, 1'b1, 2'b00, 64'h1234, 64'h100, 64'h0, 3'd0);
        tick();
        drive(5'd6, 1'b1, 2'b00, 64'h55, 64'h104, 64'h0, 3'd0);
        exp = {1'b1, 5'd5, 64'h1234, 1'b1, 64'h100};
        n_total++;
        if ({observed(), in_ready} !== {exp, 1'b1})
            $display("FAIL alu_first got %h ready=%b required %h ready=1", observed(), in_ready, exp);
        else n_pass++;
`ifdef YSYX_22040895_WBU_FWD_EN
        n_total++;
        if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 5'd5, 64'h1234})
            $display("FAIL fwd_copy got %b %h %h required 1 05 1234", fwd_valid, fwd_addr, fwd_data);
        else n_pass++;
`else
        n_total++;
        if ({fwd_valid, fwd_addr, fwd_data} !== 70'd0)
            $display("FAIL fwd_tied got %b %h %h required 0", fwd_valid, fwd_addr, fwd_data);
        else n_pass++;
`endif
        tick();
        in_valid = 1'b0;
        exp = {1'b1, 5'd6, 64'h55, 1'b1, 64'h104};
        n_total++;
        if (observed() !== exp)
            $display("FAIL alu_second got %h required %h", observed(), exp);
        else n_pass++;
        tick();
        exp = {1'b0, 5'd6, 64'h55, 1'b0, 64'h104};
        n_total++;
        if (observed() !== exp)
            $display("FAIL alu_hold got %h required %h", observed(), exp);
        else n_pass++;
    endtask

    task automatic test_lb_sign();
        logic [134:0] exp;
        for (int u = 0; u < 2; u++) begin
            drive(5'd10, 1'b1, 2'b01, 64'h1003, 64'h300, 64'h0, (u == 0) ? 3'd0 : 3'd4);
            tick();
            in_valid = 1'b0;
            tick();
            rsp_valid = 1'b1;
            rsp_data  = 64'h0000_0000_8000_0000;
            tick();
            rsp_valid = 1'b0;
            exp = {1'b1, 5'd10, (u == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80, 1'b1, 64'h300};
            n_total++;
            if (observed() !== exp)
                $display("FAIL lb_ext_%0d got %h required %h", u, observed(), exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [134:0] exp;
        drive(5'd9, 1'b1, 2'b01, 64'h2004, 64'h200, 64'h0, 3'd2);
        tick();
        drive(5'd7, 1'b1, 2'b00, 64'h77, 64'h204, 64'h0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rsp_valid = 1'b1;
                rsp_data  = 64'h8765_4321_0000_0000;
            end
            n_total++;
            if ({in_ready, commit_o} !== 2'b00)
                $display("FAIL lw_stall_%0d got ready=%b commit=%b required ready=0 commit=0",
                         i, in_ready, commit_o);
            else n_pass++;
            tick();
        end
        rsp_valid = 1'b0;
        exp = {1'b1, 5'd9, 64'hFFFF_FFFF_8765_4321, 1'b1, 64'h200};
        n_total++;
        if ({observed(), in_ready} !== {exp, 1'b1})
            $display("FAIL lw_commit got %h ready=%b required %h ready=1", observed(), in_ready, exp);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        exp = {1'b1, 5'd7, 64'h77, 1'b1, 64'h204};
        n_total++;
        if (observed() !== exp)
            $display("FAIL lw_next got %h required %h", observed(), exp);
        else n_pass++;
        tick();
    endtask

    task automatic test_jal_x0();
        logic [134:0] exp;
        logic [4:0]   t_rd  [4] = '{5'd0, 5'd1, 5'd2, 5'd3};
        logic [1:0]   t_sel [4] = '{2'b10, 2'b10, 2'b10, 2'b11};
        logic [63:0]  t_pc  [4] = '{64'h8000_0000, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40};
        logic [63:0]  t_exp [4] = '{64'h8000_0004, 64'h8000_0004, 64'h0, 64'hDEAD_0000};
        for (int i = 0; i < 4; i++) begin
            drive(t_rd[i], 1'b1, t_sel[i], 64'hABCD, t_pc[i], 64'hDEAD_0000, 3'd0);
            tick();
            in_valid = 1'b0;
            exp = {(t_rd[i] != 5'd0), t_rd[i], t_exp[i], 1'b1, t_pc[i]};
            n_total++;
            if (observed() !== exp)
                $display("FAIL jal_imm_%0d got %h required %h", i, observed(), exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        drive(5'd12, 1'b1, 2'b01, 64'h0, 64'h500, 64'h0, 3'd3);
        tick();
        in_valid  = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 64'h1122_3344_5566_7788;
        rst       = 1'b1;
        tick();
        n_total++;
        if ({observed(), in_ready} !== {135'd0, 1'b1})
            $display("FAIL rst_mid_load got %h ready=%b required 0 ready=1", observed(), in_ready);
        else n_pass++;
        rst = 1'b0;
        tick();
        rsp_valid = 1'b0;
        n_total++;
        if ({wen_o, commit_o, in_ready} !== 3'b001)
            $display("FAIL rst_after got wen=%b commit=%b ready=%b required 0 0 1",
                     wen_o, commit_o, in_ready);
        else n_pass++;
        tick();
        last_addr = 5'd0; last_data = 64'd0; last_pc = 64'd0;
    endtask

    task automatic test_random();
        logic [134:0] exp;
        logic [4:0]   r_rd;
        logic         r_we;
        logic [1:0]   r_sel;
        logic [63:0]  r_alu, r_pc, r_imm, r_data, val;
        logic [2:0]   r_f3;
        int           gap, dly, k;
        for (int it = 0; it < 300; it++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                in_valid  = 1'b0;
                rsp_valid = 1'($urandom_range(0, 1));
                rsp_data  = {$urandom, $urandom};
                repeat (gap) tick();
                exp = {1'b0, last_addr, last_data, 1'b0, last_pc};
                n_total++;
                if (observed() !== exp)
                    $display("FAIL rnd_hold_%0d got %h required %h", it, observed(), exp);
                else n_pass++;
            end
            r_rd  = 5'($urandom_range(0, 31));
            r_we  = 1'($urandom_range(0, 3) != 0);
            r_sel = 2'($urandom_range(0, 3));
            r_alu = {$urandom, $urandom};
            r_pc  = {$urandom, $urandom};
            r_imm = {$urandom, $urandom};
            r_f3  = 3'($urandom_range(0, 6));
            drive(r_rd, r_we, r_sel, r_alu, r_pc, r_imm, r_f3);
            rsp_valid = 1'($urandom_range(0, 1));
            rsp_data  = {$urandom, $urandom};
            k = 0;
            while (in_ready !== 1'b1 && k < 8) begin
                tick();
                k++;
            end
            n_total++;
            if (in_ready !== 1'b1)
                $display("FAIL rnd_ready_%0d got %b required 1", it, in_ready);
            else n_pass++;
            tick();
            in_valid  = 1'b0;
            rsp_valid = 1'b0;
            if (r_sel == 2'b01) begin
                dly = $urandom_range(0, 3);
                for (int d = 0; d < dly; d++) begin
                    n_total++;
                    if ({in_ready, commit_o} !== 2'b00)
                        $display("FAIL rnd_wait_%0d got ready=%b commit=%b required 0 0",
                                 it, in_ready, commit_o);
                    else n_pass++;
                    tick();
                end
                r_data    = {$urandom, $urandom};
                rsp_valid = 1'b1;
                rsp_data  = r_data;
                tick();
                rsp_valid = 1'b0;
                val = ref_load(r_data, int'(r_alu % 8), int'(r_f3));
            end else if (r_sel == 2'b00) begin
                val = r_alu;
            end else if (r_sel == 2'b10) begin
                val = r_pc + 64'd4;
            end else begin
                val = r_imm;
            end
            exp = {(r_we && r_rd != 5'd0), r_rd, val, 1'b1, r_pc};
            n_total++;
            if (observed() !== exp)
                $display("FAIL rnd_commit_%0d sel=%0d f3=%0d got %h required %h",
                         it, r_sel, r_f3, observed(), exp);
            else n_pass++;
            last_addr = r_rd; last_data = val; last_pc = r_pc;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rd_addr = '0; rd_wen = 1'b0; wb_sel = '0;
        alu_res = '0; pc = '0; imm = '0; ld_funct3 = '0; rsp_valid = 1'b0; rsp_data = '0;
        last_addr = '0; last_data = '0; last_pc = '0;
        test_reset();
        test_alu_back_to_back();
        test_lb_sign();
        test_lw_stall();
        test_jal_x0();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ysyx_22040895_wbu
`default_nettype wire
